// File: rtl/nios_hps_system_nios_i2csense.sv
// Avalon-MM read-back port for bit-banged I2C lines: synchronise, glitch-filter, capture edges, interrupt.
// Zero-wait-state reads; a stable pin level reaches DATA SYNC_STAGES+FILTER_CYCLES edges after first sample.
module nios_hps_system_nios_i2csense #(
  parameter int              WIDTH         = 2,
  parameter int              SYNC_STAGES   = 2,
  parameter int              FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam int PW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] filt;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] upd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] armed;
  logic [PW-1:0]    prime_cnt;
  logic             primed;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture;
  logic             wr_en;
  logic             wr_edge_sel;
  logic             wr_irq_mask;
  logic             wr_capture;
  logic             unused_wdata;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++)
      upd[i] = (synced[i] != filt[i]) && (cnt[i] == CW'(FILTER_CYCLES - 1));
  end

  assign rise     = upd & ~filt;
  assign fall     = upd & filt;
  assign edge_hit = armed & ((rise & edge_sel) | (fall & ~edge_sel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          filt[i] <= synced[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // After reset the filter may have to converge onto a line that differs from
  // RESET_VAL; that first settling transition is not a bus edge, so a line only
  // arms once the sync chain holds real samples and filt agrees with it.
  assign primed = (prime_cnt == PW'(SYNC_STAGES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_cnt <= '0;
      armed     <= '0;
    end else begin
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      armed <= armed | upd | ({WIDTH{primed}} & ~(synced ^ filt));
    end
  end

  assign wr_en       = chipselect & ~write_n;
  assign wr_edge_sel = wr_en && (address == 2'd1);
  assign wr_irq_mask = wr_en && (address == 2'd2);
  assign wr_capture  = wr_en && (address == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_sel <= '0;
      irq_mask <= '0;
      capture  <= '0;
    end else begin
      if (wr_edge_sel) edge_sel <= writedata[WIDTH-1:0];
      if (wr_irq_mask) irq_mask <= writedata[WIDTH-1:0];
      // Set is ORed in after the clear so a same-cycle edge survives W1C.
      capture <= (capture & ~({WIDTH{wr_capture}} & writedata[WIDTH-1:0])) | edge_hit;
    end
  end

  assign irq = |(capture & irq_mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt;
      2'd1:    readdata[WIDTH-1:0] = edge_sel;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      default: readdata[WIDTH-1:0] = capture;
    endcase
  end

  assign unused_wdata = ^writedata;

endmodule
